// File: rtl/axi_rr_arb.sv
// ============================================================================
// Module  : axi_rr_arb
// Brief   : Round-robin packet arbiter for one valid/ready beat channel; the
//           grant is held until the last beat of a packet is accepted.
//           Optional per-requester packet counters under AXI_ARB_STAT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_rr_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int IDW  = 2,
    parameter int CW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic [DW-1:0]        s_data,
    output logic                 s_valid,
    output logic                 s_last,
    input  logic                 s_ready,
    output logic [IDW-1:0]       grant_id,
`ifdef AXI_ARB_STAT_EN
    input  logic                 stat_clr,
    output logic [NREQ*CW-1:0]   pkt_cnt,
`endif
    output logic                 busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] ptr_q,   ptr_d;

    logic [DW-1:0]  w_data [NREQ];
    logic           w_found;
    logic [IDW-1:0] w_pick;
    logic [IDW-1:0] w_cand;
    int             w_idx;
    logic           w_xfer;
    logic           w_last_xfer;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_data[i] = req_data[i*DW +: DW];
    end

    // Search starts just after the last winner, so the latest finisher ranks lowest.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = int'(ptr_q) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            w_cand = IDW'(w_idx);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        s_data    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        if (state_q == ST_GRANT) begin
            s_data              = w_data[grant_q];
            s_valid             = req_valid[grant_q];
            s_last              = req_last[grant_q];
            req_ready[grant_q]  = s_ready;
        end
    end

    assign w_xfer      = s_valid & s_ready;
    assign w_last_xfer = w_xfer & s_last;
    assign grant_id    = grant_q;
    assign busy        = (state_q == ST_GRANT);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    grant_d = w_pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_last_xfer) begin
                    ptr_d   = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IDW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef AXI_ARB_STAT_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [CW-1:0] cnt_q;

        // Clear takes precedence over a coincident packet completion.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (stat_clr) begin
                cnt_q <= '0;
            end else if (w_last_xfer && (grant_q == IDW'(i))) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        assign pkt_cnt[i*CW +: CW] = cnt_q;
    end
`endif

endmodule

`default_nettype wire
